// File: rtl/stream_config_decoder.sv
// Stream config decoder.
// Decodes writes from the write-only config bus that fall in a 4-register
// window and queues them into three small FIFOs: in_select, out_select and
// data_type.
//   clk, rst                            clock, synchronous active-high reset
//   conf_addr/conf_data/conf_valid      config write (no backpressure)
//   in_sel_data/valid/ready             in_select stream
//   out_sel_data/valid/ready            out_select stream
//   type_data/valid/ready               data_type stream
//   overflow                            sticky: a push to a full FIFO was dropped
//   range_err                           sticky: a select write was >= NUM_SELECT
module stream_config_decoder #(
  parameter int unsigned NUM_SELECT     = 4,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned AXI_ADDR_BITS  = 32,
  parameter int unsigned AXIL_DATA_BITS = 32,
  parameter int unsigned TYPE_BITS      = 4,
  localparam int unsigned SEL_BITS      = $clog2(NUM_SELECT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ADDR_BITS-1:0]  conf_addr,
  input  logic [AXIL_DATA_BITS-1:0] conf_data,
  input  logic                      conf_valid,
  output logic [SEL_BITS-1:0]       in_sel_data,
  output logic                      in_sel_valid,
  input  logic                      in_sel_ready,
  output logic [SEL_BITS-1:0]       out_sel_data,
  output logic                      out_sel_valid,
  input  logic                      out_sel_ready,
  output logic [TYPE_BITS-1:0]      type_data,
  output logic                      type_valid,
  input  logic                      type_ready,
  output logic                      overflow,
  output logic                      range_err
);

  localparam int unsigned W        = AXIL_DATA_BITS / 8;
  localparam int unsigned WB       = $clog2(W);
  localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_BITS = PTR_BITS + 1;
  localparam int unsigned DW       = (SEL_BITS > TYPE_BITS) ? SEL_BITS : TYPE_BITS;
  localparam int unsigned NQ       = 3;

  // Address decode
  logic [AXI_ADDR_BITS-1:0] off_c;
  logic                     hit_c;
  logic [1:0]               idx_c;
  logic                     range_bad_c;
  logic                     flush_c;
  logic                     clr_c;
  logic                     range_hit_c;

  assign off_c       = conf_addr - AXI_ADDR_BITS'(BASE_ADDR);
  assign hit_c       = conf_valid && (conf_addr >= AXI_ADDR_BITS'(BASE_ADDR)) &&
                       (off_c < AXI_ADDR_BITS'(4 * W));
  assign idx_c       = off_c[WB +: 2];
  // Range check looks at the whole data word, not just the select bits.
  assign range_bad_c = (conf_data >= AXIL_DATA_BITS'(NUM_SELECT));
  assign range_hit_c = hit_c && (idx_c[1] == 1'b0) && range_bad_c;
  assign flush_c     = hit_c && (idx_c == 2'd3) && conf_data[0];
  assign clr_c       = hit_c && (idx_c == 2'd3) && conf_data[1];

  // Per-FIFO push request and payload (index 0=in_select, 1=out_select, 2=data_type)
  logic [NQ-1:0] push_req_c;
  logic [DW-1:0] pdata_c [NQ];
  logic [NQ-1:0] ready_c;

  assign push_req_c = {hit_c && (idx_c == 2'd2),
                       hit_c && (idx_c == 2'd1) && !range_bad_c,
                       hit_c && (idx_c == 2'd0) && !range_bad_c};
  assign pdata_c[0] = DW'(conf_data[SEL_BITS-1:0]);
  assign pdata_c[1] = DW'(conf_data[SEL_BITS-1:0]);
  assign pdata_c[2] = DW'(conf_data[TYPE_BITS-1:0]);
  assign ready_c    = {type_ready, out_sel_ready, in_sel_ready};

  // FIFO state
  logic [DW-1:0]       mem_q [NQ][FIFO_DEPTH];
  logic [PTR_BITS-1:0] wp_q  [NQ];
  logic [PTR_BITS-1:0] wp_d  [NQ];
  logic [PTR_BITS-1:0] rp_q  [NQ];
  logic [PTR_BITS-1:0] rp_d  [NQ];
  logic [CNT_BITS-1:0] cnt_q [NQ];
  logic [CNT_BITS-1:0] cnt_d [NQ];
  logic [NQ-1:0]       valid_q, valid_d;
  logic [NQ-1:0]       pop_c, accept_c, drop_c;
  logic                overflow_q, overflow_d;
  logic                range_err_q, range_err_d;

  // Next-state: a full FIFO still accepts a push when it pops in the same cycle
  always_comb begin
    pop_c       = '0;
    accept_c    = '0;
    drop_c      = '0;
    valid_d     = '0;
    overflow_d  = overflow_q;
    range_err_d = range_err_q;
    for (int i = 0; i < NQ; i++) begin
      wp_d[i]  = wp_q[i];
      rp_d[i]  = rp_q[i];
      cnt_d[i] = cnt_q[i];
    end

    for (int i = 0; i < NQ; i++) begin
      pop_c[i]    = valid_q[i] & ready_c[i];
      accept_c[i] = push_req_c[i] & ((cnt_q[i] != CNT_BITS'(FIFO_DEPTH)) | pop_c[i]);
      drop_c[i]   = push_req_c[i] & ~accept_c[i];
      if (flush_c) begin
        wp_d[i]  = '0;
        rp_d[i]  = '0;
        cnt_d[i] = '0;
      end else begin
        wp_d[i]  = wp_q[i] + PTR_BITS'(accept_c[i]);
        rp_d[i]  = rp_q[i] + PTR_BITS'(pop_c[i]);
        cnt_d[i] = cnt_q[i] + CNT_BITS'(accept_c[i]) - CNT_BITS'(pop_c[i]);
      end
      valid_d[i] = (cnt_d[i] != '0);
    end

    if (clr_c) begin
      overflow_d  = 1'b0;
      range_err_d = 1'b0;
    end else begin
      overflow_d  = overflow_q | (|drop_c);
      range_err_d = range_err_q | range_hit_c;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NQ; i++) begin
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
        cnt_q[i] <= '0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
      valid_q     <= '0;
      overflow_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        if (accept_c[i]) begin
          mem_q[i][wp_q[i]] <= pdata_c[i];
        end
        wp_q[i]  <= wp_d[i];
        rp_q[i]  <= rp_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      range_err_q <= range_err_d;
    end
  end

  // Head-of-queue data comes straight from storage; stale when empty
  assign in_sel_data   = SEL_BITS'(mem_q[0][rp_q[0]]);
  assign out_sel_data  = SEL_BITS'(mem_q[1][rp_q[1]]);
  assign type_data     = TYPE_BITS'(mem_q[2][rp_q[2]]);
  assign in_sel_valid  = valid_q[0];
  assign out_sel_valid = valid_q[1];
  assign type_valid    = valid_q[2];
  assign overflow      = overflow_q;
  assign range_err     = range_err_q;

endmodule

// File: tb/tb_stream_config_decoder.sv
// Directed bench for stream_config_decoder (BASE_ADDR=0x100, 32-bit data,
// NUM_SELECT=4, FIFO_DEPTH=4, 4-bit data_type).
module tb_stream_config_decoder;

  localparam logic [31:0] BASE = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] conf_addr;
  logic [31:0] conf_data;
  logic        conf_valid;
  logic [1:0]  in_sel_data, out_sel_data;
  logic        in_sel_valid, out_sel_valid, type_valid;
  logic        in_sel_ready, out_sel_ready, type_ready;
  logic [3:0]  type_data;
  logic        overflow, range_err;

  int n_cmp = 0;
  int n_err = 0;

  stream_config_decoder #(
    .NUM_SELECT(4), .BASE_ADDR(32'h100), .FIFO_DEPTH(4),
    .AXI_ADDR_BITS(32), .AXIL_DATA_BITS(32), .TYPE_BITS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .conf_addr(conf_addr), .conf_data(conf_data), .conf_valid(conf_valid),
    .in_sel_data(in_sel_data), .in_sel_valid(in_sel_valid), .in_sel_ready(in_sel_ready),
    .out_sel_data(out_sel_data), .out_sel_valid(out_sel_valid), .out_sel_ready(out_sel_ready),
    .type_data(type_data), .type_valid(type_valid), .type_ready(type_ready),
    .overflow(overflow), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One config write; returns 1 time unit after the edge that takes it
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    conf_addr  = addr;
    conf_data  = data;
    conf_valid = 1'b1;
    tick();
    conf_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; conf_addr = '0; conf_data = '0; conf_valid = 1'b0;
    in_sel_ready = 1'b0; out_sel_ready = 1'b0; type_ready = 1'b0;
    tick(); tick();
    chk("rst_in_valid",   32'(in_sel_valid), 0);
    chk("rst_out_valid",  32'(out_sel_valid), 0);
    chk("rst_type_valid", 32'(type_valid), 0);
    chk("rst_in_data",    32'(in_sel_data), 0);
    chk("rst_type_data",  32'(type_data), 0);
    chk("rst_overflow",   32'(overflow), 0);
    chk("rst_range_err",  32'(range_err), 0);
    rst = 1'b0;

    // Single writes per stream, consumers always ready
    in_sel_ready = 1'b1; out_sel_ready = 1'b1; type_ready = 1'b1;
    wr(BASE + 0, 3);
    chk("t1_in_valid", 32'(in_sel_valid), 1);
    chk("t1_in_data",  32'(in_sel_data), 3);
    wr(BASE + 4, 1);
    chk("t1_in_popped", 32'(in_sel_valid), 0);
    chk("t1_out_valid", 32'(out_sel_valid), 1);
    chk("t1_out_data",  32'(out_sel_data), 1);
    wr(BASE + 8, 2);
    chk("t1_out_popped", 32'(out_sel_valid), 0);
    chk("t1_type_valid", 32'(type_valid), 1);
    chk("t1_type_data",  32'(type_data), 2);
    tick();
    chk("t1_type_popped", 32'(type_valid), 0);

    // Fill in_select past capacity, then drain in order
    in_sel_ready = 1'b0;
    wr(BASE, 0); wr(BASE, 1); wr(BASE, 2); wr(BASE, 3);
    chk("t2_full_no_ovf", 32'(overflow), 0);
    chk("t2_head",        32'(in_sel_data), 0);
    wr(BASE, 0);
    chk("t2_overflow", 32'(overflow), 1);
    in_sel_ready = 1'b1;
    chk("t2_pop0", 32'(in_sel_data), 0);
    tick();
    chk("t2_pop1", 32'(in_sel_data), 1);
    tick();
    chk("t2_pop2", 32'(in_sel_data), 2);
    tick();
    chk("t2_pop3", 32'(in_sel_data), 3);
    tick();
    chk("t2_empty", 32'(in_sel_valid), 0);
    wr(BASE + 12, 2);
    chk("t2_ovf_clr", 32'(overflow), 0);

    // Push into a full FIFO while it pops: accepted, count stays full
    in_sel_ready = 1'b0;
    wr(BASE, 0); wr(BASE, 1); wr(BASE, 2); wr(BASE, 3);
    in_sel_ready = 1'b1;
    wr(BASE, 2);
    chk("t3_no_ovf", 32'(overflow), 0);
    chk("t3_head",   32'(in_sel_data), 1);
    in_sel_ready = 1'b0;
    wr(BASE, 0);
    chk("t3_still_full", 32'(overflow), 1);
    wr(BASE + 12, 2);
    chk("t3_ovf_clr", 32'(overflow), 0);
    in_sel_ready = 1'b1;
    chk("t3_pop1", 32'(in_sel_data), 1);
    tick();
    chk("t3_pop2", 32'(in_sel_data), 2);
    tick();
    chk("t3_pop3", 32'(in_sel_data), 3);
    tick();
    chk("t3_pop_new",   32'(in_sel_data), 2);
    chk("t3_pop_new_v", 32'(in_sel_valid), 1);
    tick();
    chk("t3_empty", 32'(in_sel_valid), 0);

    // Range error, checked ahead of a full FIFO
    in_sel_ready = 1'b0; out_sel_ready = 1'b0; type_ready = 1'b0;
    wr(BASE, 4);
    chk("t4_not_queued", 32'(in_sel_valid), 0);
    chk("t4_range_err",  32'(range_err), 1);
    chk("t4_no_ovf",     32'(overflow), 0);
    wr(BASE + 12, 2);
    chk("t4_range_clr", 32'(range_err), 0);
    wr(BASE, 0); wr(BASE, 1); wr(BASE, 2); wr(BASE, 3);
    wr(BASE, 32'h104);
    chk("t4b_range_err", 32'(range_err), 1);
    chk("t4b_no_ovf",    32'(overflow), 0);
    wr(BASE + 12, 3);
    chk("t4b_flags_clr", 32'(range_err | overflow), 0);
    chk("t4b_flushed",   32'(in_sel_valid), 0);

    // Flush all three FIFOs
    wr(BASE, 1); wr(BASE, 2);
    wr(BASE + 4, 0); wr(BASE + 4, 3);
    wr(BASE + 8, 32'h1F5); wr(BASE + 8, 7);
    chk("t5_in_head",   32'(in_sel_data), 1);
    chk("t5_out_head",  32'(out_sel_data), 0);
    chk("t5_type_head", 32'(type_data), 5);
    chk("t5_valids",    32'({in_sel_valid, out_sel_valid, type_valid}), 32'h7);
    wr(BASE + 12, 1);
    chk("t5_flushed", 32'({in_sel_valid, out_sel_valid, type_valid}), 0);
    wr(BASE + 4, 1);
    chk("t5_out_valid", 32'(out_sel_valid), 1);
    chk("t5_out_data",  32'(out_sel_data), 1);
    chk("t5_in_empty",  32'(in_sel_valid), 0);

    // Flush in a cycle where the consumer pops
    wr(BASE + 4, 2);
    out_sel_ready = 1'b1;
    wr(BASE + 12, 1);
    out_sel_ready = 1'b0;
    chk("t5b_flushed", 32'(out_sel_valid), 0);
    wr(BASE + 4, 3);
    chk("t5b_push_v", 32'(out_sel_valid), 1);
    chk("t5b_push_d", 32'(out_sel_data), 3);
    tick();
    chk("t5b_hold_v", 32'(out_sel_valid), 1);
    wr(BASE + 12, 1);

    // Out-of-window writes are ignored
    wr(BASE - 4, 7);
    wr(BASE + 16, 9);
    wr(BASE + 28, 3);
    chk("t6_no_valid", 32'({in_sel_valid, out_sel_valid, type_valid}), 0);
    chk("t6_no_flags", 32'({overflow, range_err}), 0);

    // Reset mid-operation, with a write presented during the reset cycle
    wr(BASE, 2); wr(BASE + 4, 3); wr(BASE + 8, 4); wr(BASE, 9);
    chk("t7_pre_valids", 32'({in_sel_valid, out_sel_valid, type_valid}), 32'h7);
    chk("t7_pre_range",  32'(range_err), 1);
    rst = 1'b1;
    conf_addr = BASE; conf_data = 1; conf_valid = 1'b1;
    tick();
    conf_valid = 1'b0;
    rst = 1'b0;
    chk("t7_valids",    32'({in_sel_valid, out_sel_valid, type_valid}), 0);
    chk("t7_data",      32'({in_sel_data, out_sel_data, type_data}), 0);
    chk("t7_flags",     32'({overflow, range_err}), 0);
    tick();
    chk("t7_ignored_wr", 32'(in_sel_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
